// File: rtl/period_meter_pkg.sv
// Shared types and constants for the multi-channel period meter.
// Imported by the per-channel block and the top-level wrapper.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS
  } state_t;

  localparam int SYNC_STAGES = 2;

  // One accumulator holds 2^avg_log2 samples of cnt_w bits without overflow.
  function automatic int acc_width(input int cnt_w, input int avg_log2);
    return cnt_w + avg_log2;
  endfunction

endpackage

// File: rtl/period_meter_chan.sv
// One measured input: synchronizer, period/high counters, window FSM and result registers.
// Results appear the cycle after the rise that completes a window; the counters never stop between windows.
module period_meter_chan
  import period_meter_pkg::*;
#(
  parameter int CNT_W     = 24,
  parameter int AVG_LOG2  = 2,
  parameter int MAX_COUNT = 2**20,
  parameter int TOL       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             locked,
  input  logic             meas_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             update,
  output logic             stable,
  output logic             timeout
);

  localparam int ACC_W = acc_width(CNT_W, AVG_LOG2);
  localparam int WIN_W = AVG_LOG2 + 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] TOL_CNT  = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s, s_d, rise;
  logic [CNT_W-1:0]       cnt, hcnt;
  logic [ACC_W-1:0]       acc, hacc;
  logic [WIN_W-1:0]       win;
  logic                   pend;
  logic                   cnt_run, arm_rise, add_sample, fire_to, publish, go_idle, cnt_hit;
  logic [CNT_W-1:0]       mean_p, mean_h, diff;

  assign s       = sync[SYNC_STAGES-1];
  assign rise    = s & ~s_d;
  assign cnt_hit = (cnt == MAX_CNT);
  assign mean_p  = acc[AVG_LOG2 +: CNT_W];
  assign mean_h  = hacc[AVG_LOG2 +: CNT_W];
  assign diff    = (mean_p >= period_out) ? (mean_p - period_out) : (period_out - mean_p);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      s_d   <= 1'b0;
      state <= IDLE;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], meas_in};
      s_d   <= s;
      state <= state_n;
    end
  end

  // A rise always beats a timeout; locked low beats everything, including a pending publish.
  always_comb begin
    state_n    = state;
    cnt_run    = 1'b0;
    arm_rise   = 1'b0;
    add_sample = 1'b0;
    fire_to    = 1'b0;
    publish    = 1'b0;
    go_idle    = ~locked;
    case (state)
      IDLE: begin
        if (locked) state_n = ARM;
      end
      ARM: begin
        if (!locked) begin
          state_n = IDLE;
        end else begin
          cnt_run = 1'b1;
          if (rise) begin
            arm_rise = 1'b1;
            state_n  = MEAS;
          end else if (cnt_hit) begin
            fire_to = 1'b1;
          end
        end
      end
      MEAS: begin
        if (!locked) begin
          state_n = IDLE;
        end else begin
          cnt_run = 1'b1;
          publish = pend;
          if (rise) begin
            add_sample = 1'b1;
          end else if (cnt_hit) begin
            fire_to = 1'b1;
            state_n = ARM;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (!cnt_run) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt  <= CNT_W'(1);
      hcnt <= '0;
    end else begin
      if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      if (s_d && hcnt != CNT_SAT) hcnt <= hcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      hacc       <= '0;
      win        <= '0;
      pend       <= 1'b0;
      period_out <= '0;
      high_out   <= '0;
      valid      <= 1'b0;
      update     <= 1'b0;
      stable     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      update <= 1'b0;
      pend   <= 1'b0;
      if (arm_rise || publish || go_idle) begin
        acc  <= '0;
        hacc <= '0;
        win  <= '0;
      end
      // Minimum input period is 2 clk, so a sample never lands in the publish cycle.
      if (add_sample) begin
        acc  <= acc + ACC_W'(cnt);
        hacc <= hacc + ACC_W'(hcnt);
        win  <= win + 1'b1;
        pend <= (win == WIN_LAST);
      end
      if (publish) begin
        period_out <= mean_p;
        high_out   <= mean_h;
        valid      <= 1'b1;
        update     <= 1'b1;
        timeout    <= 1'b0;
        stable     <= valid && (diff <= TOL_CNT);
      end
      if (fire_to) begin
        timeout <= 1'b1;
        valid   <= 1'b0;
        stable  <= 1'b0;
      end
      if (go_idle) begin
        valid   <= 1'b0;
        stable  <= 1'b0;
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/period_meter.sv
// Multi-channel period and high-time meter: CHANNELS independent measurement channels.
// Buses are packed with channel i at [i*CNT_W +: CNT_W].
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int CNT_W     = 24,
  parameter int AVG_LOG2  = 2,
  parameter int MAX_COUNT = 2**20,
  parameter int TOL       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      locked,
  input  logic [CHANNELS-1:0]       meas_in,
  output logic [CHANNELS*CNT_W-1:0] period_out,
  output logic [CHANNELS*CNT_W-1:0] high_out,
  output logic [CHANNELS-1:0]       valid,
  output logic [CHANNELS-1:0]       update,
  output logic [CHANNELS-1:0]       stable,
  output logic [CHANNELS-1:0]       timeout
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    period_meter_chan #(
      .CNT_W    (CNT_W),
      .AVG_LOG2 (AVG_LOG2),
      .MAX_COUNT(MAX_COUNT),
      .TOL      (TOL)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .locked    (locked),
      .meas_in   (meas_in[i]),
      .period_out(period_out[i*CNT_W +: CNT_W]),
      .high_out  (high_out[i*CNT_W +: CNT_W]),
      .valid     (valid[i]),
      .update    (update[i]),
      .stable    (stable[i]),
      .timeout   (timeout[i])
    );
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Multi-channel period and high-time meter. Successor to the single-channel period helper.
- Counts cycles of one fast sampling clock between rising edges of each asynchronous measured input.
- Averages over a configurable window and flags timeout and stability per channel.
- Feeds lock-detect and frequency-check logic in the PLL model. Fully synthesizable: no delays, integer cycle counts only.

Parameters:
CHANNELS, 2, number of independent measured inputs (1..16)
CNT_W, 24, width of period/high-time counters and outputs
AVG_LOG2, 2, window = 2^AVG_LOG2 periods averaged per result (0..4)
MAX_COUNT, 2**20, cycles without rising edge before timeout (< 2^CNT_W)
TOL, 2, max |difference| in cycles between consecutive results for stable

Ports:
clk  in  1  sampling clock, all logic on posedge
reset  in  1  asynchronous, active-high; clears all state and outputs
locked  in  1  global enable; high = inputs reliable, low = all channels held idle
meas_in  in  CHANNELS  asynchronous signals to measure
period_out  out  CHANNELS*CNT_W  averaged period in clk cycles; channel i at [i*CNT_W +: CNT_W]
high_out  out  CHANNELS*CNT_W  averaged high time in clk cycles; same packing
valid  out  CHANNELS  result registers hold a completed window
update  out  CHANNELS  1-cycle pulse when a new result is written
stable  out  CHANNELS  last two results within TOL
timeout  out  CHANNELS  sticky: no rising edge for MAX_COUNT cycles

Behaviour:
- Reset values: period_out=0, high_out=0, valid=0, update=0, stable=0, timeout=0. Channel state IDLE; counters and accumulators 0.
- Input path per channel:
  - 2-FF synchronizer, then a previous-value register.
  - Rising edge rise = s & ~s_d; falling edge fall = ~s & s_d.
  - Detection latency is 3 clk. The latency is identical for every edge, so it cancels in measurements.
- Counters:
  - cnt: on rise, cnt<=1; otherwise cnt<=cnt+1, saturating at 2^CNT_W-1.
  - hcnt: on rise, hcnt<=0; otherwise hcnt increments while s_d=1, saturating.
  - Period sample = cnt at the rise cycle. Example: input period 10 clk gives 10.
  - High sample = hcnt at the rise cycle, i.e. cycles s_d was high since the previous rise.
- Per-channel state machine:
  - IDLE: locked=0. Counters held 0; valid and stable cleared; period_out/high_out keep their last value. When locked=1, go to ARM.
  - ARM: on rise, start counters, clear the accumulators and window counter, go to MEAS.
  - MEAS: each rise adds the period and high samples to the accumulators (width CNT_W+AVG_LOG2) and increments the window counter.
  - When 2^AVG_LOG2 samples are collected, in the cycle after the last rise:
    - period_out = acc>>AVG_LOG2 and high_out = hacc>>AVG_LOG2 (truncating).
    - valid=1, update pulses 1 cycle.
    - stable = valid_before && |new−old| ≤ TOL.
    - Accumulators restart with the following window; the counter is already running, so no edge is lost between windows.
  - Timeout: cnt reaching MAX_COUNT in ARM or MEAS sets timeout=1, clears valid and stable, goes to ARM. An input stuck at either level, or no edge at all, times out.
  - timeout clears on the next update of that channel, or on locked=0.
  - locked falling in any state goes to IDLE next cycle and aborts any partial window; no update.
- Simultaneous events:
  - rise and timeout in the same cycle: rise wins; no timeout.
  - locked low and window completion in the same cycle: IDLE wins; no update.
- Reset asserted mid-window: everything returns to reset values asynchronously. After reset release, the first update requires ARM + full window.
- Channels are fully independent; no shared arbitration.

Decomposition:
- Package period_meter_pkg:
  - state enum {IDLE, ARM, MEAS}
  - SYNC_STAGES=2
  - accumulator width function CNT_W+AVG_LOG2
- Sub-module period_meter_chan: one channel (synchronizer, counters, FSM, result registers). The top module generates CHANNELS instances and packs the buses.

Test Plan:
- CHANNELS=2, AVG_LOG2=2; ch0 period 10 clk with 4 high; ch1 period 37 with 20 high; locked=1 → after 5 rises each: period_out 10/37, high_out 4/20, valid=1, update pulses every 40/148 clk, stable=1 from the second window.
- ch0 alternating periods 9,11 → average 10 exactly; jitter 10→14 with TOL=2 → stable drops on the window mean that differs by more than 2.
- MAX_COUNT=100; stop ch0 toggling → timeout=1 at 100 cycles after the last rise, valid=0; ch1 unaffected; resume toggling → timeout clears at the first update.
- Drop locked mid-window → next cycle IDLE, valid=0, no update, period_out retains its old value; raise locked → ARM, first update after 1+4 rises.
- Assert reset asynchronously between clk edges mid-window → all outputs 0 immediately; after release, normal measurement resumes.
- Period 1-cycle-high pulses of 3-clk period → period_out=3, high_out=1; counter saturation with MAX_COUNT=2^CNT_W-1 and CNT_W=8 → cnt holds at 255 without wrap.
